// File: rtl/mem_pkg.sv
// Shared types and defaults for the data memory arbiter slice.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Which requester (if any) owns the read data returning this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // One memory request as presented by either requester.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter; full tells the arbiter the debug port has waited long enough.
module starve_counter #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);

  logic [W-1:0] cnt;

  // Clear dominates increment; increment stops once the limit is reached.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign full = (cnt == W'(MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the debug port.
// CPU has fixed priority; the debug port is forced through after STARVE_MAX lost cycles.
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   starve_full;
  owner_e rd_owner;

  // Debug waits while the CPU is busy, so it counts while requesting but not granted.
  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (4)
  ) u_dbg_starve (
    .CLK  (CLK),
    .rst  (rst),
    .inc  (dbg_req & ~dbg_gnt),
    .clr  (dbg_gnt | ~dbg_req),
    .full (starve_full)
  );

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    dbg_gnt = rst & dbg_req & (starve_full | ~cpu_req);
    cpu_gnt = rst & cpu_req & ~dbg_gnt;
  end

  assign cpu_stall = rst & cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dbg_gnt;

  // Steer the winner onto the memory port; idle cycles present a harmless read of 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Remember who issued this cycle's read so next cycle's memory output goes back to them.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner <= OWN_DBG;
    end else if (cpu_gnt && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // A reset arriving while read data is in flight kills the return immediately.
  always_comb begin
    cpu_rvalid = rst & (rd_owner == OWN_CPU);
    dbg_rvalid = rst & (rd_owner == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a write-first memory model.
module tb_data_mem_arbiter;

  logic        CLK;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] mem_array [256];

  int checks;
  int failures;

  data_mem_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (16),
    .STARVE_MAX (4)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .cpu_gnt    (cpu_gnt),
    .dbg_gnt    (dbg_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .dbg_rvalid (dbg_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single-port write-first memory with a registered read port.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_array[mem_addr] <= mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= mem_array[mem_addr];
      end
    end
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'd0; cpu_wdata = 16'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'd0; dbg_wdata = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd0; cpu_wdata = 16'h1234;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      checks++;
      if ({cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, mem_en} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_ctrl cycle %0d: got %b expected 000000", i,
                 {cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, mem_en});
      end
      checks++;
      if ({cpu_rdata, dbg_rdata} !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_rdata cycle %0d: got %h expected 0", i, {cpu_rdata, dbg_rdata});
      end
    end
    @(negedge CLK);
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_en} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL reset_release_gnt: got %b expected 1001", {cpu_gnt, dbg_gnt, cpu_stall, mem_en});
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if ({cpu_rvalid, dbg_rvalid, mem_en} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_release_after_write: got %b expected 000", {cpu_rvalid, dbg_rvalid, mem_en});
    end
  endtask

  task automatic test_dbg_only();
    @(negedge CLK);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd5; dbg_wdata = 16'hBEEF;
    #1;
    checks++;
    if ({dbg_gnt, cpu_gnt, mem_we, mem_addr} !== {3'b101, 8'd5}) begin
      failures++;
      $display("[TB] FAIL dbg_write_gnt: got %b/%0d expected 101/5", {dbg_gnt, cpu_gnt, mem_we}, mem_addr);
    end
    @(negedge CLK);
    dbg_we = 1'b0;
    #1;
    checks++;
    if ({dbg_gnt, dbg_rvalid, cpu_rvalid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL dbg_read_gnt: got %b expected 100", {dbg_gnt, dbg_rvalid, cpu_rvalid});
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if ({dbg_rvalid, dbg_rdata} !== {1'b1, 16'hBEEF}) begin
      failures++;
      $display("[TB] FAIL dbg_read_data: got rvalid=%b rdata=%h expected 1/beef", dbg_rvalid, dbg_rdata);
    end
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL dbg_read_cpu_quiet: got rvalid=%b rdata=%h expected 0/0", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] expected;
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd20; cpu_wdata = 16'h0A0A;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd21; dbg_wdata = 16'h5555;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      expected = (c == 4) ? 3'b011 : 3'b100;
      checks++;
      if ({cpu_gnt, dbg_gnt, cpu_stall} !== expected) begin
        failures++;
        $display("[TB] FAIL starve_cycle%0d: got gnt/dgnt/stall=%b expected %b", c,
                 {cpu_gnt, dbg_gnt, cpu_stall}, expected);
      end
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd3; dbg_wdata = 16'd245;
    @(negedge CLK);
    dbg_addr = 8'd7; dbg_wdata = 16'd29890;
    @(negedge CLK);
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd3;
    #1;
    checks++;
    if ({cpu_gnt, cpu_rvalid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_first_gnt: got %b expected 10", {cpu_gnt, cpu_rvalid});
    end
    @(negedge CLK);
    cpu_addr = 8'd7;
    #1;
    checks++;
    if ({cpu_gnt, cpu_rvalid, cpu_rdata} !== {2'b11, 16'd245}) begin
      failures++;
      $display("[TB] FAIL b2b_data0: got gnt/rvalid=%b rdata=%0d expected 11/245", {cpu_gnt, cpu_rvalid}, cpu_rdata);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'd29890}) begin
      failures++;
      $display("[TB] FAIL b2b_data1: got rvalid=%b rdata=%0d expected 1/29890", cpu_rvalid, cpu_rdata);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end: got rvalid=%b expected 0", cpu_rvalid);
    end
  endtask

  task automatic test_contention();
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd7;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 5) dbg_req = 1'b0;
      if (c == 6) cpu_req = 1'b0;
      #1;
      if (c == 1 || c == 6) begin
        checks++;
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b1, 16'd245, 1'b0, 16'd0}) begin
          failures++;
          $display("[TB] FAIL contention_cpu_cycle%0d: got cpu %b/%0d dbg %b/%0d expected cpu 1/245 dbg 0/0",
                   c, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
        end
      end
      if (c == 4) begin
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_addr} !== {2'b01, 8'd7}) begin
          failures++;
          $display("[TB] FAIL contention_forced_gnt: got %b addr=%0d expected 01 addr=7", {cpu_gnt, dbg_gnt}, mem_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if ({dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 16'd29890, 1'b0, 16'd0}) begin
          failures++;
          $display("[TB] FAIL contention_dbg: got dbg %b/%0d cpu %b/%0d expected dbg 1/29890 cpu 0/0",
                   dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata);
        end
      end
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset_after_read();
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd7;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_rd_gnt: got %b expected 1", cpu_gnt);
    end
    @(negedge CLK);
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL rst_rd_during: got rvalid=%b rdata=%h expected 0/0", cpu_rvalid, cpu_rdata);
    end
    @(negedge CLK);
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== 18'h0) begin
      failures++;
      $display("[TB] FAIL rst_rd_after: got rvalid=%b/%b rdata=%h expected 0/0/0", cpu_rvalid, dbg_rvalid, cpu_rdata);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_dbg_only();
    test_starvation();
    test_back_to_back();
    test_contention();
    test_reset_after_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
